// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct values, ALU and memory-length
// codes, immediate-format selectors and the ctrl_t bundle produced by id_decoder.
package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_NOR    = 4'd5;
    localparam logic [3:0] ALU_SLT    = 4'd6;
    localparam logic [3:0] ALU_SLTU   = 4'd7;
    localparam logic [3:0] ALU_SLL    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_SRA    = 4'd10;
    localparam logic [3:0] ALU_LUI    = 4'd11;
    localparam logic [3:0] ALU_BEQ    = 4'd12;
    localparam logic [3:0] ALU_BNE    = 4'd13;

    localparam logic [1:0] MEMLEN_BYTE = 2'd0;
    localparam logic [1:0] MEMLEN_WORD = 2'd2;

    localparam logic [1:0] IMM_SEXT   = 2'd0;
    localparam logic [1:0] IMM_ZEXT   = 2'd1;
    localparam logic [1:0] IMM_LUI    = 2'd2;
    localparam logic [1:0] IMM_SHAMT  = 2'd3;

    typedef struct packed {
        logic [3:0] alusel;
        logic [1:0] imm_sel;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] wa;
        logic       regwe;
        logic       memrd;
        logic       memwe;
        logic [1:0] memlen;
        logic       is_branch;
        logic       br_ne;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decoder: opcode/funct/rt/rd fields to the ctrl_t bundle.
// Unrecognised encodings raise illegal and decode as a NOP with no sources.
module id_decoder
    import id_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl.alusel  = ALU_ADD;
        ctrl.imm_sel = IMM_SEXT;
        ctrl.memlen  = MEMLEN_WORD;
        case (opcode)
            OP_SPECIAL: begin
                ctrl.use_rs = 1'b1;
                ctrl.use_rt = 1'b1;
                ctrl.wa     = rd;
                ctrl.regwe  = 1'b1;
                case (funct)
                    FN_SLL: begin
                        ctrl.alusel  = ALU_SLL;
                        ctrl.use_rs  = 1'b0;
                        ctrl.imm_sel = IMM_SHAMT;
                    end
                    FN_SRL: begin
                        ctrl.alusel  = ALU_SRL;
                        ctrl.use_rs  = 1'b0;
                        ctrl.imm_sel = IMM_SHAMT;
                    end
                    FN_SRA: begin
                        ctrl.alusel  = ALU_SRA;
                        ctrl.use_rs  = 1'b0;
                        ctrl.imm_sel = IMM_SHAMT;
                    end
                    FN_ADDU: ctrl.alusel = ALU_ADD;
                    FN_SUBU: ctrl.alusel = ALU_SUB;
                    FN_AND:  ctrl.alusel = ALU_AND;
                    FN_OR:   ctrl.alusel = ALU_OR;
                    FN_XOR:  ctrl.alusel = ALU_XOR;
                    FN_NOR:  ctrl.alusel = ALU_NOR;
                    FN_SLT:  ctrl.alusel = ALU_SLT;
                    FN_SLTU: ctrl.alusel = ALU_SLTU;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.use_rs = (opcode != OP_LUI);
                ctrl.wa     = rt;
                ctrl.regwe  = 1'b1;
                case (opcode)
                    OP_SLTI: ctrl.alusel = ALU_SLT;
                    OP_ANDI: begin
                        ctrl.alusel  = ALU_AND;
                        ctrl.imm_sel = IMM_ZEXT;
                    end
                    OP_ORI: begin
                        ctrl.alusel  = ALU_OR;
                        ctrl.imm_sel = IMM_ZEXT;
                    end
                    OP_XORI: begin
                        ctrl.alusel  = ALU_XOR;
                        ctrl.imm_sel = IMM_ZEXT;
                    end
                    OP_LUI: begin
                        ctrl.alusel  = ALU_LUI;
                        ctrl.imm_sel = IMM_LUI;
                    end
                    default: ctrl.alusel = ALU_ADD;
                endcase
            end
            OP_LB, OP_LBU, OP_LW: begin
                ctrl.use_rs = 1'b1;
                ctrl.wa     = rt;
                ctrl.regwe  = 1'b1;
                ctrl.memrd  = 1'b1;
                ctrl.memlen = (opcode == OP_LW) ? MEMLEN_WORD : MEMLEN_BYTE;
            end
            OP_SB, OP_SW: begin
                ctrl.use_rs = 1'b1;
                ctrl.use_rt = 1'b1;
                ctrl.memwe  = 1'b1;
                ctrl.memlen = (opcode == OP_SW) ? MEMLEN_WORD : MEMLEN_BYTE;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.use_rs    = 1'b1;
                ctrl.use_rt    = 1'b1;
                ctrl.is_branch = 1'b1;
                ctrl.br_ne     = (opcode == OP_BNE);
                ctrl.alusel    = (opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        if (ctrl.illegal) begin
            ctrl.regwe  = 1'b0;
            ctrl.memrd  = 1'b0;
            ctrl.memwe  = 1'b0;
            ctrl.use_rs = 1'b0;
            ctrl.use_rt = 1'b0;
            ctrl.wa     = 5'd0;
        end
        // $0 is never written, so a write to it is dropped here once for all formats
        if (ctrl.wa == 5'd0) ctrl.regwe = 1'b0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: decode, register read with WB bypass, load-use hazard, ID/EX register.
// Define ID_BRANCH_EN to resolve BEQ/BNE in ID and drive redir_valid/redir_pc.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALU_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_inst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    input  logic              flush,
    output logic [REG_AW-1:0] rf_ra1,
    output logic [REG_AW-1:0] rf_ra2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_wa,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [ALU_W-1:0]  ex_alusel,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wa,
    output logic              ex_regwe,
    output logic              ex_memrd,
    output logic              ex_memwe,
    output logic [1:0]        ex_memlen,
    output logic              ex_illegal,
    output logic              redir_valid,
    output logic [XLEN-1:0]   redir_pc,
    input  logic              exm_we,
    input  logic [REG_AW-1:0] exm_wa,
    input  logic [XLEN-1:0]   exm_wd,
    input  logic              exm_memrd
);

    function automatic logic [XLEN-1:0] ext_imm(input logic [1:0] sel, input logic [15:0] imm,
                                                input logic [4:0] sa);
        logic signed [15:0] simm;
        logic signed [31:0] lui;
        simm = imm;
        lui  = {imm, 16'h0000};
        case (sel)
            IMM_ZEXT:  return XLEN'(imm);
            IMM_LUI:   return XLEN'(lui);
            IMM_SHAMT: return XLEN'(sa);
            default:   return XLEN'(simm);
        endcase
    endfunction

    function automatic logic src_hit(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt, input logic use_rs,
                                     input logic use_rt);
        return (r != '0) && ((use_rs && r == rs) || (use_rt && r == rt));
    endfunction

    ctrl_t             ctrl_p0;
    logic [REG_AW-1:0] rs_p0, rt_p0;
    logic [XLEN-1:0]   a_p0, b_p0, imm_p0;
    logic              load_use, br_haz, hazard, adv, issue_p0, br_nop;

    logic              vld_p1, regwe_p1, memrd_p1, memwe_p1, illegal_p1;
    logic [XLEN-1:0]   pc_p1, a_p1, b_p1, imm_p1;
    logic [ALU_W-1:0]  alusel_p1;
    logic [REG_AW-1:0] rs_p1, rt_p1, wa_p1;
    logic [1:0]        memlen_p1;

    // ---- ID (p0): decode, register read, bypass, hazard ----
    id_decoder u_dec (
        .opcode (if_inst[31:26]),
        .funct  (if_inst[5:0]),
        .rt     (if_inst[20:16]),
        .rd     (if_inst[15:11]),
        .ctrl   (ctrl_p0)
    );

    assign rs_p0  = REG_AW'(if_inst[25:21]);
    assign rt_p0  = REG_AW'(if_inst[20:16]);
    assign rf_ra1 = rs_p0;
    assign rf_ra2 = rt_p0;
    assign imm_p0 = ext_imm(ctrl_p0.imm_sel, if_inst[15:0], if_inst[10:6]);

    always_comb begin
        a_p0 = rf_rd1;
        b_p0 = rf_rd2;
        if (wb_we && wb_wa == rs_p0) a_p0 = wb_wd;
        if (wb_we && wb_wa == rt_p0) b_p0 = wb_wd;
        if (rs_p0 == '0) a_p0 = '0;
        if (rt_p0 == '0) b_p0 = '0;
    end

    assign load_use = vld_p1 && memrd_p1 &&
                      src_hit(wa_p1, rs_p0, rt_p0, ctrl_p0.use_rs, ctrl_p0.use_rt);
    assign hazard   = load_use | br_haz;
    assign adv      = ex_ready | ~vld_p1;
    assign id_ready = adv & ~hazard & ~flush;
    assign issue_p0 = if_valid & ~hazard;

`ifdef ID_BRANCH_EN
    logic [XLEN-1:0] br_a, br_b, br_target;
    logic            br_taken, br_accept, redir_vld_p1;
    logic [XLEN-1:0] redir_pc_p1;

    // EX/MEM results are newer than WB, so they win the compare-operand bypass
    always_comb begin
        br_a = a_p0;
        br_b = b_p0;
        if (exm_we && exm_wa == rs_p0 && rs_p0 != '0) br_a = exm_wd;
        if (exm_we && exm_wa == rt_p0 && rt_p0 != '0) br_b = exm_wd;
    end

    assign br_haz = ctrl_p0.is_branch &&
                    ((vld_p1 && regwe_p1 &&
                      src_hit(wa_p1, rs_p0, rt_p0, ctrl_p0.use_rs, ctrl_p0.use_rt)) ||
                     (exm_memrd &&
                      src_hit(exm_wa, rs_p0, rt_p0, ctrl_p0.use_rs, ctrl_p0.use_rt)));
    assign br_taken  = ctrl_p0.is_branch & (ctrl_p0.br_ne ? (br_a != br_b) : (br_a == br_b));
    assign br_accept = if_valid & id_ready & br_taken;
    assign br_target = if_pc + XLEN'(4) + (imm_p0 << 2);
    assign br_nop    = ctrl_p0.is_branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_vld_p1 <= 1'b0;
            redir_pc_p1  <= '0;
        end else begin
            redir_vld_p1 <= br_accept;
            if (br_accept) redir_pc_p1 <= br_target;
        end
    end

    assign redir_valid = redir_vld_p1;
    assign redir_pc    = redir_pc_p1;
`else
    logic unused_exm;
    assign unused_exm  = ^{exm_we, exm_wa, exm_wd, exm_memrd};
    assign br_haz      = 1'b0;
    assign br_nop      = 1'b0;
    assign redir_valid = 1'b0;
    assign redir_pc    = '0;
`endif

    // ---- ID/EX (p1) register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            alusel_p1  <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
            imm_p1     <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            wa_p1      <= '0;
            regwe_p1   <= 1'b0;
            memrd_p1   <= 1'b0;
            memwe_p1   <= 1'b0;
            memlen_p1  <= '0;
            illegal_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            regwe_p1 <= 1'b0;
            memrd_p1 <= 1'b0;
            memwe_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1     <= issue_p0;
            pc_p1      <= if_pc;
            alusel_p1  <= br_nop ? ALU_W'(ALU_ADD) : ALU_W'(ctrl_p0.alusel);
            a_p1       <= a_p0;
            b_p1       <= b_p0;
            imm_p1     <= imm_p0;
            rs_p1      <= rs_p0;
            rt_p1      <= rt_p0;
            wa_p1      <= REG_AW'(ctrl_p0.wa);
            regwe_p1   <= ctrl_p0.regwe & issue_p0;
            memrd_p1   <= ctrl_p0.memrd & issue_p0;
            memwe_p1   <= ctrl_p0.memwe & issue_p0;
            memlen_p1  <= ctrl_p0.memlen;
            illegal_p1 <= ctrl_p0.illegal & issue_p0;
        end
    end

    assign ex_valid   = vld_p1;
    assign ex_pc      = pc_p1;
    assign ex_alusel  = alusel_p1;
    assign ex_a       = a_p1;
    assign ex_b       = b_p1;
    assign ex_imm     = imm_p1;
    assign ex_rs      = rs_p1;
    assign ex_rt      = rt_p1;
    assign ex_wa      = wa_p1;
    assign ex_regwe   = regwe_p1;
    assign ex_memrd   = memrd_p1;
    assign ex_memwe   = memwe_p1;
    assign ex_memlen  = memlen_p1;
    assign ex_illegal = illegal_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed testbench for id_stage_pipe (XLEN=32); branch checks adapt to ID_BRANCH_EN.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst, if_pc;
    logic        id_ready, flush;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        ex_ready, ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [3:0]  ex_alusel;
    logic [4:0]  ex_rs, ex_rt, ex_wa;
    logic        ex_regwe, ex_memrd, ex_memwe, ex_illegal;
    logic [1:0]  ex_memlen;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        exm_we, exm_memrd;
    logic [4:0]  exm_wa;
    logic [31:0] exm_wd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Register file model: $r holds 0x1000+r; $0 returns junk the DUT must mask
    always_comb begin
        rf_rd1 = (rf_ra1 == 5'd0) ? 32'hDEADBEEF : 32'h1000 + 32'(rf_ra1);
        rf_rd2 = (rf_ra2 == 5'd0) ? 32'hDEADBEEF : 32'h1000 + 32'(rf_ra2);
    end

    id_stage_pipe #(.XLEN(32), .REG_AW(5), .ALU_W(4)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alusel(ex_alusel),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_wa(ex_wa), .ex_regwe(ex_regwe), .ex_memrd(ex_memrd), .ex_memwe(ex_memwe),
        .ex_memlen(ex_memlen), .ex_illegal(ex_illegal), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .exm_we(exm_we), .exm_wa(exm_wa), .exm_wd(exm_wd),
        .exm_memrd(exm_memrd)
    );

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sa, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sa), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; if_valid = 1'b0; if_inst = 32'h0; if_pc = 32'h0; flush = 1'b0;
        wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'h0; ex_ready = 1'b1;
        exm_we = 1'b0; exm_wa = 5'd0; exm_wd = 32'h0; exm_memrd = 1'b0;
        tick(); tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
        checks++; if (ex_pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", ex_pc); end
        checks++; if (ex_imm !== 32'h0 || ex_a !== 32'h0) begin failures++; $display("FAIL rst_data: imm %h a %h want 0", ex_imm, ex_a); end
        checks++; if (redir_valid !== 1'b0) begin failures++; $display("FAIL rst_redir: got %b want 0", redir_valid); end
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL rst_id_ready: got %b want 1", id_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_immediates;
        issue(itype(6'h09, 0, 2, -1), 32'h40);
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h40) begin failures++; $display("FAIL addiu_issue: valid %b pc %h want 1 00000040", ex_valid, ex_pc); end
        checks++; if (ex_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL addiu_imm: got %h want ffffffff", ex_imm); end
        checks++; if (ex_wa !== 5'd2 || ex_regwe !== 1'b1 || ex_alusel !== 4'd0) begin failures++; $display("FAIL addiu_ctrl: wa %0d we %b alu %0d want 2 1 0", ex_wa, ex_regwe, ex_alusel); end
        checks++; if (ex_a !== 32'h0) begin failures++; $display("FAIL addiu_r0: got %h want 0", ex_a); end
        issue(itype(6'h0D, 0, 2, 16'h8000), 32'h44);
        checks++; if (ex_imm !== 32'h00008000 || ex_alusel !== 4'd3) begin failures++; $display("FAIL ori_imm: imm %h alu %0d want 00008000 3", ex_imm, ex_alusel); end
        issue(rtype(0, 5, 4, 31, 6'h00), 32'h48);
        checks++; if (ex_imm !== 32'd31 || ex_alusel !== 4'd8) begin failures++; $display("FAIL sll_imm: imm %h alu %0d want 0000001f 8", ex_imm, ex_alusel); end
        checks++; if (ex_b !== 32'h1005 || ex_rt !== 5'd5 || ex_wa !== 5'd4) begin failures++; $display("FAIL sll_ops: b %h rt %0d wa %0d want 1005 5 4", ex_b, ex_rt, ex_wa); end
        issue(itype(6'h0F, 0, 6, 16'h8001), 32'h4C);
        checks++; if (ex_imm !== 32'h80010000 || ex_alusel !== 4'd11) begin failures++; $display("FAIL lui_imm: imm %h alu %0d want 80010000 11", ex_imm, ex_alusel); end
        issue(itype(6'h3F, 1, 2, 0), 32'h50);
        checks++; if (ex_illegal !== 1'b1 || ex_regwe !== 1'b0 || ex_memwe !== 1'b0) begin failures++; $display("FAIL illegal_op: ill %b we %b mwe %b want 1 0 0", ex_illegal, ex_regwe, ex_memwe); end
        issue(rtype(1, 2, 0, 0, 6'h21), 32'h54);
        checks++; if (ex_regwe !== 1'b0 || ex_illegal !== 1'b0) begin failures++; $display("FAIL addu_r0_dest: we %b ill %b want 0 0", ex_regwe, ex_illegal); end
        issue(rtype(1, 2, 3, 0, 6'h3F), 32'h58);
        checks++; if (ex_illegal !== 1'b1 || ex_regwe !== 1'b0) begin failures++; $display("FAIL illegal_funct: ill %b we %b want 1 0", ex_illegal, ex_regwe); end
    endtask

    task automatic test_bypass;
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hA5A5A5A5;
        issue(rtype(5, 6, 7, 0, 6'h21), 32'h60);
        checks++; if (ex_a !== 32'hA5A5A5A5 || ex_b !== 32'h1006) begin failures++; $display("FAIL byp_rs: a %h b %h want a5a5a5a5 00001006", ex_a, ex_b); end
        wb_wa = 5'd6;
        issue(rtype(5, 6, 7, 0, 6'h21), 32'h64);
        checks++; if (ex_a !== 32'h1005 || ex_b !== 32'hA5A5A5A5) begin failures++; $display("FAIL byp_rt: a %h b %h want 00001005 a5a5a5a5", ex_a, ex_b); end
        wb_wa = 5'd0;
        issue(rtype(0, 6, 7, 0, 6'h21), 32'h68);
        checks++; if (ex_a !== 32'h0 || ex_b !== 32'h1006) begin failures++; $display("FAIL byp_r0: a %h b %h want 0 00001006", ex_a, ex_b); end
        wb_we = 1'b0;
    endtask

    task automatic test_load_use;
        if_valid = 1'b1; if_inst = itype(6'h23, 1, 3, 0); if_pc = 32'h200;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lw_ready: got %b want 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_memrd !== 1'b1 || ex_memlen !== 2'd2 || ex_wa !== 5'd3) begin failures++; $display("FAIL lw_issue: v %b rd %b len %0d wa %0d want 1 1 2 3", ex_valid, ex_memrd, ex_memlen, ex_wa); end
        if_inst = rtype(3, 3, 4, 0, 6'h21); if_pc = 32'h204;
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_stall: id_ready %b want 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_memrd !== 1'b0 || ex_regwe !== 1'b0) begin failures++; $display("FAIL lu_bubble: v %b rd %b we %b want 0 0 0", ex_valid, ex_memrd, ex_regwe); end
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_release: id_ready %b want 1", id_ready); end
        tick();
        if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_wa !== 5'd4 || ex_pc !== 32'h204 || ex_alusel !== 4'd0) begin failures++; $display("FAIL lu_addu: v %b wa %0d pc %h alu %0d want 1 4 00000204 0", ex_valid, ex_wa, ex_pc, ex_alusel); end
    endtask

    task automatic test_backpressure;
        ex_ready = 1'b1;
        issue(rtype(1, 2, 8, 0, 6'h21), 32'h300);
        checks++; if (ex_valid !== 1'b1 || ex_wa !== 5'd8) begin failures++; $display("FAIL bp_first: v %b wa %0d want 1 8", ex_valid, ex_wa); end
        ex_ready = 1'b0;
        if_valid = 1'b1; if_inst = rtype(1, 2, 9, 0, 6'h26); if_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_%0d: got %b want 0", i, id_ready); end
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_wa !== 5'd8 || ex_pc !== 32'h300) begin failures++; $display("FAIL bp_hold_%0d: v %b wa %0d pc %h want 1 8 00000300", i, ex_valid, ex_wa, ex_pc); end
        end
        flush = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", id_ready); end
        tick();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL flush_after_ready: got %b want 1", id_ready); end
        tick();
        if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_wa !== 5'd9 || ex_alusel !== 4'd4) begin failures++; $display("FAIL bp_xor: v %b wa %0d alu %0d want 1 9 4", ex_valid, ex_wa, ex_alusel); end
        ex_ready = 1'b1;
        tick();
    endtask

    task automatic test_mid_reset;
        issue(itype(6'h09, 1, 10, 5), 32'h400);
        checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'd5) begin failures++; $display("FAIL mr_pre: v %b imm %h want 1 00000005", ex_valid, ex_imm); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_a !== 32'h0 || ex_imm !== 32'h0 || ex_wa !== 5'd0 || ex_regwe !== 1'b0) begin failures++; $display("FAIL mr_clear: v %b pc %h a %h imm %h wa %0d we %b want all 0", ex_valid, ex_pc, ex_a, ex_imm, ex_wa, ex_regwe); end
        #1 rst = 1'b0;
        issue(itype(6'h09, 1, 11, 7), 32'h404);
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h404 || ex_imm !== 32'd7 || ex_a !== 32'h1001) begin failures++; $display("FAIL mr_first: v %b pc %h imm %h a %h want 1 00000404 00000007 00001001", ex_valid, ex_pc, ex_imm, ex_a); end
    endtask

    task automatic test_branch;
        issue(itype(6'h04, 1, 1, 4), 32'h100);
`ifdef ID_BRANCH_EN
        checks++; if (redir_valid !== 1'b1 || redir_pc !== 32'h114) begin failures++; $display("FAIL beq_redir: v %b pc %h want 1 00000114", redir_valid, redir_pc); end
        checks++; if (ex_valid !== 1'b1 || ex_alusel !== 4'd0 || ex_regwe !== 1'b0) begin failures++; $display("FAIL beq_nop: v %b alu %0d we %b want 1 0 0", ex_valid, ex_alusel, ex_regwe); end
        tick();
        checks++; if (redir_valid !== 1'b0) begin failures++; $display("FAIL beq_pulse: got %b want 0", redir_valid); end
        issue(itype(6'h05, 1, 1, 4), 32'h120);
        checks++; if (redir_valid !== 1'b0) begin failures++; $display("FAIL bne_eq: got %b want 0", redir_valid); end
`else
        checks++; if (ex_alusel !== 4'd12 || ex_imm !== 32'd4 || ex_a !== 32'h1001 || ex_regwe !== 1'b0) begin failures++; $display("FAIL beq_ex: alu %0d imm %h a %h we %b want 12 00000004 00001001 0", ex_alusel, ex_imm, ex_a, ex_regwe); end
        checks++; if (redir_valid !== 1'b0 || redir_pc !== 32'h0) begin failures++; $display("FAIL beq_noredir: v %b pc %h want 0 0", redir_valid, redir_pc); end
        issue(itype(6'h05, 1, 2, 16'hFFFF), 32'h120);
        checks++; if (ex_alusel !== 4'd13 || ex_imm !== 32'hFFFFFFFF || ex_b !== 32'h1002) begin failures++; $display("FAIL bne_ex: alu %0d imm %h b %h want 13 ffffffff 00001002", ex_alusel, ex_imm, ex_b); end
`endif
    endtask

    initial begin
        test_reset();
        test_immediates();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_mid_reset();
        test_branch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
